// File: rtl/timer_uart_tx.sv
// Serialises a captured timer snapshot as "HH:MM:SS[!]\r\n" on an 8N1 UART line.
// The line is built from registered snapshot values, so input changes mid-message have no effect.
module timer_uart_tx #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       send,
   input  logic [5:0] hours,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   input  logic       done,
   output logic       tx,
   output logic       busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       bit_reg, bit_next;
   logic [3:0]       byte_reg, byte_next;
   logic [5:0]       hours_reg, hours_next;
   logic [5:0]       minutes_reg, minutes_next;
   logic [5:0]       seconds_reg, seconds_next;
   logic             done_reg, done_next;
   logic             tx_reg, tx_next;
   logic             busy_reg, busy_next;

   logic [2:0][5:0]  field_val;
   logic [2:0][7:0]  tens_ascii;
   logic [2:0][7:0]  ones_ascii;
   logic [7:0]       cur_byte;
   logic             last_byte;
   logic             bit_end;
   logic [2:0]       bit_inc;

   // Field order: [2] hours, [1] minutes, [0] seconds.
   assign field_val = {hours_reg, minutes_reg, seconds_reg};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_digit
         logic [5:0] tens;
         logic [5:0] ones;
         assign tens           = field_val[gi] / 6'd10;
         assign ones           = field_val[gi] % 6'd10;
         assign tens_ascii[gi] = 8'h30 + {2'b00, tens};
         assign ones_ascii[gi] = 8'h30 + {2'b00, ones};
      end
   endgenerate

   always_comb begin
      cur_byte = 8'h0A;
      case (byte_reg)
         4'd0:    cur_byte = tens_ascii[2];
         4'd1:    cur_byte = ones_ascii[2];
         4'd2:    cur_byte = 8'h3A;
         4'd3:    cur_byte = tens_ascii[1];
         4'd4:    cur_byte = ones_ascii[1];
         4'd5:    cur_byte = 8'h3A;
         4'd6:    cur_byte = tens_ascii[0];
         4'd7:    cur_byte = ones_ascii[0];
         4'd8:    cur_byte = done_reg ? 8'h21 : 8'h0D;
         4'd9:    cur_byte = done_reg ? 8'h0D : 8'h0A;
         default: cur_byte = 8'h0A;
      endcase
   end

   assign last_byte = (byte_reg == (done_reg ? 4'd10 : 4'd9));
   assign bit_end   = (cnt_reg == CNT_LAST);
   assign bit_inc   = bit_reg + 3'd1;

   // tx_next is the level of the bit that begins after this edge, so tx stays a pure register.
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      bit_next     = bit_reg;
      byte_next    = byte_reg;
      hours_next   = hours_reg;
      minutes_next = minutes_reg;
      seconds_next = seconds_reg;
      done_next    = done_reg;
      tx_next      = tx_reg;
      busy_next    = busy_reg;

      case (state_reg)
         S_IDLE: begin
            tx_next   = 1'b1;
            busy_next = 1'b0;
            if (send) begin
               state_next   = S_START;
               cnt_next     = '0;
               bit_next     = 3'd0;
               byte_next    = 4'd0;
               hours_next   = hours;
               minutes_next = minutes;
               seconds_next = seconds;
               done_next    = done;
               tx_next      = 1'b0;
               busy_next    = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_next = S_DATA;
               cnt_next   = '0;
               bit_next   = 3'd0;
               tx_next    = cur_byte[0];
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_next = '0;
               if (bit_reg == 3'd7) begin
                  state_next = S_STOP;
                  tx_next    = 1'b1;
               end else begin
                  bit_next = bit_inc;
                  tx_next  = cur_byte[bit_inc];
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cnt_next = '0;
               bit_next = 3'd0;
               if (last_byte) begin
                  state_next = S_IDLE;
                  byte_next  = 4'd0;
                  tx_next    = 1'b1;
                  busy_next  = 1'b0;
               end else begin
                  state_next = S_START;
                  byte_next  = byte_reg + 4'd1;
                  tx_next    = 1'b0;
               end
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
         default: begin
            state_next = S_IDLE;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= S_IDLE;
         cnt_reg     <= '0;
         bit_reg     <= 3'd0;
         byte_reg    <= 4'd0;
         hours_reg   <= 6'd0;
         minutes_reg <= 6'd0;
         seconds_reg <= 6'd0;
         done_reg    <= 1'b0;
         tx_reg      <= 1'b1;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         bit_reg     <= bit_next;
         byte_reg    <= byte_next;
         hours_reg   <= hours_next;
         minutes_reg <= minutes_next;
         seconds_reg <= seconds_next;
         done_reg    <= done_next;
         tx_reg      <= tx_next;
         busy_reg    <= busy_next;
      end
   end

   assign tx   = tx_reg;
   assign busy = busy_reg;

endmodule
